// File: rtl/powerup_ctrl_pkg.sv
// Shared types and constants for the power-pack controller and its frame timing helpers.
package powerup_ctrl_pkg;

    localparam int FRAME_CNT_W = 10;

    localparam logic PLAYER_LEFT  = 1'b0;
    localparam logic PLAYER_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        EFFECT = 2'd2
    } pu_state_e;

    // Strict interval overlap: touching edges do not count.
    function automatic logic spans_overlap(input logic [11:0] a_lo, input logic [11:0] a_hi,
                                           input logic [11:0] b_lo, input logic [11:0] b_hi);
        return (a_lo < b_hi) && (a_hi > b_lo);
    endfunction

endpackage

// File: rtl/powerup_ctrl_if.sv
// Video position, ball/pack geometry and power-up outputs shared between the pack logic and its users.
interface powerup_ctrl_if;
    import powerup_ctrl_pkg::*;

    logic [10:0]            hcount;
    logic [FRAME_CNT_W-1:0] vcount;
    logic [10:0]            ball_x;
    logic [9:0]             ball_y;
    logic                   last_hitter;
    logic [10:0]            rx;
    logic [9:0]             ry;
    logic                   spawn;
    logic                   eaten;
    logic                   effect_active;
    logic                   effect_owner;
    logic [FRAME_CNT_W-1:0] frames_left;

    modport master (
        output hcount, vcount, ball_x, ball_y, last_hitter, rx, ry,
        input  spawn, eaten, effect_active, effect_owner, frames_left
    );

    modport slave (
        input  hcount, vcount, ball_x, ball_y, last_hitter, rx, ry,
        output spawn, eaten, effect_active, effect_owner, frames_left
    );

endinterface

// File: rtl/powerup_ctrl_frame_tick_gen.sv
// One-cycle frame tick derived from the video origin; shared by pack, score and ball-speed logic.
module frame_tick_gen
    import powerup_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [10:0]            hcount,
    input  logic [FRAME_CNT_W-1:0] vcount,
    output logic                   tick
);

    logic origin_d;
    logic origin_q;
    logic origin_prev_q;
    logic tick_q;

    assign origin_d = (hcount == '0) && (vcount == '0);

    // Rising-edge detect keeps a single tick even if the origin is held for several clocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            origin_q      <= 1'b0;
            origin_prev_q <= 1'b0;
            tick_q        <= 1'b0;
        end else begin
            origin_q      <= origin_d;
            origin_prev_q <= origin_q;
            tick_q        <= origin_q && !origin_prev_q;
        end
    end

    assign tick = tick_q && !reset;

endmodule

// File: rtl/powerup_ctrl.sv
// Power-pack spawn timer, per-frame ball/pack collision check and timed power-up effect.
//   state  | meaning
//   IDLE   | counting frames down to the next pack spawn
//   ARMED  | pack on screen, checking ball overlap once per frame
//   EFFECT | pack eaten, power-up running for the credited player
module powerup_ctrl
    import powerup_ctrl_pkg::*;
#(
    parameter logic [FRAME_CNT_W-1:0] SPAWN_FRAMES  = 10'd300,
    parameter logic [FRAME_CNT_W-1:0] EFFECT_FRAMES = 10'd600,
    parameter int                     PACK_W        = 20,
    parameter int                     PACK_H        = 20,
    parameter int                     BALL_SIZE     = 16
) (
    input  logic          clk,
    input  logic          reset,
    powerup_ctrl_if.slave bus
);

    logic tick;

    frame_tick_gen u_tick (
        .clk    (clk),
        .reset  (reset),
        .hcount (bus.hcount),
        .vcount (bus.vcount),
        .tick   (tick)
    );

    logic [11:0] ball_l, ball_r, ball_t, ball_b;
    logic [11:0] pack_l, pack_r, pack_t, pack_b;
    logic        pack_parked;
    logic        hit;

    // 12-bit edges so right/bottom sums never wrap.
    assign ball_l = {1'b0, bus.ball_x};
    assign ball_r = ball_l + 12'(BALL_SIZE);
    assign ball_t = {2'b00, bus.ball_y};
    assign ball_b = ball_t + 12'(BALL_SIZE);
    assign pack_l = {1'b0, bus.rx};
    assign pack_r = pack_l + 12'(PACK_W);
    assign pack_t = {2'b00, bus.ry};
    assign pack_b = pack_t + 12'(PACK_H);

    assign pack_parked = (bus.rx == '0) && (bus.ry == '0);
    assign hit = !pack_parked
               && spans_overlap(ball_l, ball_r, pack_l, pack_r)
               && spans_overlap(ball_t, ball_b, pack_t, pack_b);

    pu_state_e              state_q;
    logic [FRAME_CNT_W-1:0] frames_left_q;
    logic                   spawn_q;
    logic                   eaten_q;
    logic                   effect_active_q;
    logic                   effect_owner_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            frames_left_q   <= SPAWN_FRAMES;
            spawn_q         <= 1'b0;
            eaten_q         <= 1'b0;
            effect_active_q <= 1'b0;
            effect_owner_q  <= PLAYER_LEFT;
        end else begin
            spawn_q <= 1'b0;
            eaten_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    IDLE: begin
                        if (frames_left_q == FRAME_CNT_W'(1)) begin
                            state_q       <= ARMED;
                            frames_left_q <= '0;
                            spawn_q       <= 1'b1;
                        end else begin
                            frames_left_q <= frames_left_q - 1'b1;
                        end
                    end
                    ARMED: begin
                        if (hit) begin
                            state_q         <= EFFECT;
                            frames_left_q   <= EFFECT_FRAMES;
                            eaten_q         <= 1'b1;
                            effect_active_q <= 1'b1;
                            effect_owner_q  <= bus.last_hitter;
                        end
                    end
                    EFFECT: begin
                        if (frames_left_q == FRAME_CNT_W'(1)) begin
                            state_q         <= IDLE;
                            frames_left_q   <= SPAWN_FRAMES;
                            effect_active_q <= 1'b0;
                        end else begin
                            frames_left_q <= frames_left_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q       <= IDLE;
                        frames_left_q <= SPAWN_FRAMES;
                    end
                endcase
            end
        end
    end

    assign bus.spawn         = spawn_q;
    assign bus.eaten         = eaten_q;
    assign bus.effect_active = effect_active_q;
    assign bus.effect_owner  = effect_owner_q;
    assign bus.frames_left   = frames_left_q;

endmodule

// File: tb/tb_powerup_ctrl.sv
// Frame-level randomized bench for powerup_ctrl against a per-frame behavioural model.
module tb_powerup_ctrl;
    import powerup_ctrl_pkg::*;

    localparam logic [9:0] SP = 10'd3;
    localparam logic [9:0] EF = 10'd6;
    localparam int PW = 20;
    localparam int PH = 20;
    localparam int BS = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    powerup_ctrl_if bus();

    powerup_ctrl #(
        .SPAWN_FRAMES  (SP),
        .EFFECT_FRAMES (EF),
        .PACK_W        (PW),
        .PACK_H        (PH),
        .BALL_SIZE     (BS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {M_IDLE, M_ARMED, M_EFFECT} model_mode_e;

    model_mode_e m_mode;
    int          m_left;
    bit          m_active;
    bit          m_owner;
    bit          exp_spawn;
    bit          exp_eaten;
    int          checks   = 0;
    int          failures = 0;
    int          frame_no = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s frame=%0d: got %0d expected %0d", tag, frame_no, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode    = M_IDLE;
        m_left    = SP;
        m_active  = 1'b0;
        m_owner   = 1'b0;
        exp_spawn = 1'b0;
        exp_eaten = 1'b0;
    endtask

    task automatic model_tick(input int bx, input int by, input int px, input int py, input bit hitter);
        bit touching;
        touching  = !(px == 0 && py == 0)
                  && (bx < px + PW) && (bx + BS > px)
                  && (by < py + PH) && (by + BS > py);
        exp_spawn = 1'b0;
        exp_eaten = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (m_left == 1) begin
                    m_mode    = M_ARMED;
                    m_left    = 0;
                    exp_spawn = 1'b1;
                end else begin
                    m_left--;
                end
            end
            M_ARMED: begin
                if (touching) begin
                    m_mode    = M_EFFECT;
                    m_left    = EF;
                    m_active  = 1'b1;
                    m_owner   = hitter;
                    exp_eaten = 1'b1;
                end
            end
            default: begin
                if (m_left == 1) begin
                    m_mode   = M_IDLE;
                    m_left   = SP;
                    m_active = 1'b0;
                end else begin
                    m_left--;
                end
            end
        endcase
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_spawn"}, bus.spawn, exp_spawn);
        check_eq({tag, "_eaten"}, bus.eaten, exp_eaten);
        check_eq({tag, "_frames_left"}, bus.frames_left, m_left);
        check_eq({tag, "_effect_active"}, bus.effect_active, m_active);
        check_eq({tag, "_effect_owner"}, bus.effect_owner, m_owner);
        if (m_mode != M_ARMED)
            check_eq({tag, "_frames_left_nonzero"}, bus.frames_left != '0, 1);
    endtask

    // One video frame: origin on cycle 0, tick lands on edge 1, outputs update on edge 2.
    // rst_k >= 0 pulses reset so that it is sampled on edge rst_k of this frame.
    task automatic run_frame(input int bx, input int by, input int px, input int py,
                             input bit hitter, input int len, input int rst_k);
        int extras;
        extras = 0;
        frame_no++;
        if (rst_k >= 0 && rst_k <= 2) model_reset();
        else model_tick(bx, by, px, py, hitter);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.hcount      = '0;
                bus.vcount      = '0;
                bus.ball_x      = 11'(bx);
                bus.ball_y      = 10'(by);
                bus.rx          = 11'(px);
                bus.ry          = 10'(py);
                bus.last_hitter = hitter;
            end else begin
                bus.hcount = 11'($urandom_range(1, 1500));
                bus.vcount = 10'($urandom_range(0, 600));
            end
            reset = (k == rst_k);
            @(posedge clk);
            #1;
            if (k == rst_k && rst_k > 2) model_reset();
            if (k == 2) check_state("tick");
            else if (k == rst_k) check_state("reset_mid");
            else extras += int'(bus.spawn) + int'(bus.eaten);
        end
        reset = 1'b0;
        check_eq("pulse_outside_tick", extras, 0);
    endtask

    initial begin
        int px, py, bx, by, len, rk;
        reset           = 1'b1;
        bus.hcount      = 11'd5;
        bus.vcount      = 10'd5;
        bus.ball_x      = '0;
        bus.ball_y      = '0;
        bus.rx          = '0;
        bus.ry          = '0;
        bus.last_hitter = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_state("reset");
        @(negedge clk);
        reset = 1'b0;

        repeat (3) run_frame(0, 0, 0, 0, 0, 6, -1);
        run_frame(684, 500, 700, 500, 1, 5, -1);
        run_frame(690, 495, 700, 500, 1, 5, -1);
        repeat (6) run_frame(100, 100, 700, 500, 0, 4, -1);
        repeat (3) run_frame(0, 0, 0, 0, 1, 4, -1);
        repeat (5) run_frame(0, 0, 0, 0, 1, 5, -1);
        run_frame(684, 500, 700, 500, 0, 4, -1);
        run_frame(685, 500, 700, 500, 0, 4, -1);
        run_frame(685, 500, 700, 500, 1, 4, -1);
        run_frame(685, 500, 700, 500, 1, 5, 1);
        repeat (3) run_frame(300, 300, 0, 0, 1, 4, -1);

        for (int f = 0; f < 250; f++) begin
            if ($urandom_range(0, 7) == 0) begin
                px = 0;
                py = 0;
                bx = $urandom_range(0, 30);
                by = $urandom_range(0, 30);
            end else begin
                px = $urandom_range(40, 1000);
                py = $urandom_range(40, 400);
                bx = px + $urandom_range(0, 48) - 22;
                by = py + $urandom_range(0, 48) - 22;
            end
            len = $urandom_range(4, 9);
            rk  = ($urandom_range(0, 24) == 0) ? $urandom_range(0, len - 1) : -1;
            run_frame(bx, by, px, py, 1'($urandom_range(0, 1)), len, rk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/powerup_ctrl.md
Name: powerup_ctrl

Overview:
Upstream controller for the power-pack sprite. Counts video frames to decide when a pack spawns. Checks once per frame whether the ball overlaps the pack, and issues the spawn/eaten pulses the sprite stage consumes. After the pack is eaten, it holds a timed power-up effect credited to the player who last hit the ball; the paddle logic reads this effect.

Parameters:
SPAWN_FRAMES, 10'd300, frames spent in IDLE before a pack spawns (legal range 1..1023)
EFFECT_FRAMES, 10'd600, frames the effect stays active after a pack is eaten (legal range 1..1023)
PACK_W, 20, pack width in pixels; must match the sprite stage WIDTH
PACK_H, 20, pack height in pixels; must match the sprite stage HEIGHT
BALL_SIZE, 16, ball side length in pixels

Ports:
clk  input  1  system pixel clock; the block uses this single clock only
reset  input  1  synchronous, active-high reset
hcount  input  11  current horizontal pixel count
vcount  input  10  current vertical line count
ball_x  input  11  ball top-left x
ball_y  input  10  ball top-left y
last_hitter  input  1  player who last touched the ball: 0 = left, 1 = right
rx  input  11  pack top-left x, from the sprite stage
ry  input  10  pack top-left y, from the sprite stage
spawn  output  1  one-cycle pulse that places the pack
eaten  output  1  one-cycle pulse that removes the pack
effect_active  output  1  high while the power-up effect is running
effect_owner  output  1  player credited with the effect
frames_left  output  10  remaining frames in the current IDLE or EFFECT countdown

Behaviour:
- All state updates on posedge clk. When reset=1: state=IDLE, frames_left=SPAWN_FRAMES, and spawn, eaten, effect_active and effect_owner are all 0. Reset overrides every other event, including reset arriving mid-EFFECT or mid-ARMED.
- Frame tick: an internal one-cycle pulse. It is asserted on the cycle after the registered detection of hcount==0 && vcount==0, so there is exactly one tick per frame. It is never asserted during reset.
- IDLE: on each tick, frames_left decrements. When a tick arrives with frames_left==1, the block moves to ARMED and asserts spawn for exactly 1 cycle. frames_left is undefined-free: it reads 0 while ARMED.
- ARMED: the collision check runs only on ticks, and never on the tick that entered ARMED.
- Collision condition: ball_x < rx+PACK_W && ball_x+BALL_SIZE > rx && ball_y < ry+PACK_H && ball_y+BALL_SIZE > ry. All sums are computed at 12 bits so they cannot wrap.
- Parked pack: rx==0 && ry==0 means the pack is parked, and collision is suppressed.
- On a collision, the following all happen in the same cycle, and the eaten pulse is 1 cycle wide:
  - eaten=1
  - effect_owner <= last_hitter
  - effect_active <= 1
  - frames_left <= EFFECT_FRAMES
  - state <= EFFECT
- EFFECT: on each tick, frames_left decrements. When a tick arrives with frames_left==1, the block does the following and asserts no spawn on that cycle:
  - effect_active <= 0
  - frames_left <= SPAWN_FRAMES
  - state <= IDLE
- ARMED has no timeout. The pack stays until it is eaten or reset occurs.
- spawn and eaten are never high in the same cycle.
- effect_owner holds its value after the effect ends and changes only on the next eaten pulse.
- Latency:
  - spawn and eaten rise 2 cycles after the hcount/vcount origin sample.
  - Collision uses the ball_x, ball_y, rx and ry values sampled in the tick cycle.
- A frames_left of 0 in IDLE or EFFECT cannot occur, because parameters are ≥1. The bench asserts this.

Decomposition:
- Shared package: state enum (IDLE=2'd0, ARMED=2'd1, EFFECT=2'd2), the frame-counter width constant FRAME_CNT_W=10, and the player encoding constants PLAYER_LEFT and PLAYER_RIGHT.
- One natural sub-module: frame_tick_gen. Inputs are clk, reset, hcount and vcount; output is tick. It is reusable by score and ball-speed logic.
- The overlap compare stays inline as combinational logic inside powerup_ctrl.

Test Plan:
- Reset, then 3 frames with SPAWN_FRAMES=3 -> spawn pulses exactly once, 1 cycle wide, on the 3rd tick; state=ARMED; effect_active=0.
- ARMED with rx=700, ry=500 and the ball at (690,495), 16px -> overlap, so eaten pulses on the next tick; effect_owner equals last_hitter=1; frames_left=EFFECT_FRAMES.
- ARMED with the ball at (684,500) -> ball_x+16==rx, so no eaten pulse (edge-touch excluded). Moving the ball to (685,500) -> eaten pulses on the next tick.
- ARMED with rx=0, ry=0 and the ball at (0,0) -> no eaten pulse across 5 ticks.
- EFFECT_FRAMES=2 after eaten -> effect_active falls on the 2nd tick; frames_left reloads to SPAWN_FRAMES; the next spawn pulse follows SPAWN_FRAMES ticks later.
- reset asserted for 1 cycle mid-EFFECT with frames_left=5 -> the next cycle shows IDLE, effect_active=0, frames_left=SPAWN_FRAMES, and no spurious spawn or eaten pulse.
